// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Imported by the interface, the timer and the top level.
package mem_port_arbiter_pkg;

  localparam int unsigned DefTimeout = 16;
  localparam int unsigned DefAw      = 32;
  localparam int unsigned DataW      = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StServI = 2'd1,
    StServD = 2'd2
  } state_e;

  // Round-robin pick: D wins when it is the only requester or when I was served last.
  function automatic logic pick_d(input logic i_elig, input logic d_elig, input logic last_d);
    return d_elig && (!i_elig || !last_d);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and unified memory handshakes around the arbiter.
// slave is the arbiter's view; master is the view of the surrounding core and memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = DefAw
);

  logic             i_req;
  logic [AW-1:0]    i_addr;
  logic [DataW-1:0] i_rdata;
  logic             i_ready;

  logic             d_req;
  logic             d_we;
  logic [AW-1:0]    d_addr;
  logic [DataW-1:0] d_wdata;
  logic [DataW-1:0] d_rdata;
  logic             d_ready;

  logic             m_req;
  logic             m_we;
  logic [AW-1:0]    m_addr;
  logic [DataW-1:0] m_wdata;
  logic [DataW-1:0] m_rdata;
  logic             m_ack;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_flop.sv
// Enable flop with synchronous active-low clear; the codebase's standard capture cell.
module mem_arb_flop #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter_timer.sv
// Service-cycle counter: expired is high once TIMEOUT-1 ack-less cycles have been counted.
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CntW'(TIMEOUT - 1));

  // Holding at the terminal value keeps expired from wrapping away before the FSM reacts.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with a per-access timeout that aborts with zero data and a sticky error flag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned AW      = DefAw
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                err_timeout
);

  localparam int unsigned CapW = 1 + AW + DataW;

  state_e           state_q, state_d;
  logic             serving;
  logic             i_elig, d_elig;
  logic             grant_i, grant_d, grant;
  logic             done_i, done_d;
  logic             expired, abort;
  logic             last_d_q;
  logic [CapW-1:0]  cap_d, cap_q;
  logic [DataW-1:0] resp_data;

  assign serving = (state_q != StIdle);
  assign busy    = serving;

  // The ready cycle still carries the finished request, so that side sits out one grant.
  assign i_elig = bus.i_req && !bus.i_ready;
  assign d_elig = bus.d_req && !bus.d_ready;

  assign grant     = grant_i || grant_d;
  assign abort     = serving && expired && !bus.m_ack;
  assign resp_data = bus.m_ack ? bus.m_rdata : '0;

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done_i  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_d(i_elig, d_elig, last_d_q)) begin
          grant_d = 1'b1;
          state_d = StServD;
        end else if (i_elig) begin
          grant_i = 1'b1;
          state_d = StServI;
        end
      end
      StServI: begin
        if (bus.m_ack || expired) begin
          done_i  = 1'b1;
          state_d = StIdle;
        end
      end
      StServD: begin
        if (bus.m_ack || expired) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetches never write; their wdata field keeps whatever the last store left there.
  always_comb begin
    cap_d = cap_q;
    if (grant_d) begin
      cap_d = {bus.d_we, bus.d_addr, bus.d_wdata};
    end else if (grant_i) begin
      cap_d = {1'b0, bus.i_addr, cap_q[DataW-1:0]};
    end
  end

  mem_arb_flop #(.Width(CapW)) u_cap (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .d   (cap_d),
    .q   (cap_q)
  );

  assign bus.m_req = serving;
  assign {bus.m_we, bus.m_addr, bus.m_wdata} = cap_q;

  mem_arb_flop #(.Width(1)) u_last (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .d   (grant_d),
    .q   (last_d_q)
  );

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant),
    .enable  (serving && !bus.m_ack),
    .expired (expired)
  );

  mem_arb_flop #(.Width(DataW)) u_i_rdata (
    .clk (clk),
    .rst (rst),
    .en  (done_i),
    .d   (resp_data),
    .q   (bus.i_rdata)
  );

  mem_arb_flop #(.Width(DataW)) u_d_rdata (
    .clk (clk),
    .rst (rst),
    .en  (done_d),
    .d   (resp_data),
    .q   (bus.d_rdata)
  );

  mem_arb_flop #(.Width(1)) u_i_ready (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (done_i),
    .q   (bus.i_ready)
  );

  mem_arb_flop #(.Width(1)) u_d_ready (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (done_d),
    .q   (bus.d_ready)
  );

  mem_arb_flop #(.Width(1)) u_err (
    .clk (clk),
    .rst (rst),
    .en  (abort),
    .d   (1'b1),
    .q   (err_timeout)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err_timeout;

  mem_port_arbiter_if #(.AW(32)) bus ();

  mem_port_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] e_i;
  logic [31:0] e_d;

  typedef struct {
    bit          side;      // 0 = fetch, 1 = data
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;     // SERV cycles before the acked one; large = never ack
    bit          drop;      // release req right after the grant
    int          exp_lat;   // cycles from req to ready
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int serv;
    int lat;
    serv = 0;
    lat  = -1;
    if (v.side) begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end else begin
      bus.i_req  = 1'b1;
      bus.i_addr = v.addr;
    end
    bus.m_rdata = v.rdata;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      bus.m_ack = 1'b0;
      if (bus.m_req) begin
        chk("vec_m_addr", bus.m_addr, v.addr);
        chk("vec_m_we", 32'(bus.m_we), 32'(v.we));
        if (v.we) chk("vec_m_wdata", bus.m_wdata, v.wdata);
        bus.m_ack = (serv == v.delay);
        serv++;
      end
      tick();
      if (v.drop) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
      if (v.side ? bus.d_ready : bus.i_ready) lat = c + 1;
    end
    bus.m_ack = 1'b0;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk("vec_latency", lat, v.exp_lat);
    if (v.side) e_d = v.exp_rdata;
    else        e_i = v.exp_rdata;
    chk("vec_i_rdata", bus.i_rdata, e_i);
    chk("vec_d_rdata", bus.d_rdata, e_d);
    chk("vec_err", 32'(err_timeout), 32'(v.exp_err));
    tick();
    chk("vec_ready_pulse", 32'({bus.i_ready, bus.d_ready}), 32'd0);
  endtask

  // Both sides request continuously with instant acks: D first, then strict alternation.
  task automatic run_alternation();
    int k;
    k = 0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h200;
    for (int c = 0; c < 40 && k < 8; c++) begin
      bus.m_ack = 1'b0;
      if (bus.m_req) begin
        chk("alt_order", bus.m_addr, (k % 2 == 0) ? 32'h200 : 32'h100);
        chk("alt_slot", 32'(c), 32'(2 * k + 1));
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hA000_0000 | 32'(k);
        k++;
      end
      tick();
    end
    chk("alt_count", 32'(k), 32'd8);
    clear_inputs();
    tick();
    tick();
    e_i = 32'hA000_0007;
    e_d = 32'hA000_0006;
    chk("alt_i_rdata", bus.i_rdata, e_i);
    chk("alt_d_rdata", bus.d_rdata, e_d);
  endtask

  task automatic run_reset_mid_serv();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h70;
    bus.m_ack  = 1'b0;
    tick();
    chk("rst_mid_m_req_before", 32'(bus.m_req), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    rst         = 1'b1;
    bus.d_req   = 1'b0;
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h99;
    chk("rst_mid_m_req", 32'(bus.m_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_m_addr", bus.m_addr, 32'd0);
    tick();
    chk("rst_mid_d_ready", 32'(bus.d_ready), 32'd0);
    chk("rst_mid_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_mid_err", 32'(err_timeout), 32'd0);
    chk("rst_mid_m_req_after", 32'(bus.m_req), 32'd0);
    bus.m_ack = 1'b0;
    tick();
    chk("rst_mid_d_ready_late", 32'(bus.d_ready), 32'd0);
  endtask

  // Transaction-level model: at most one access in flight, picked by eligibility and
  // round-robin, finished by an ack or after TO ack-less service cycles.
  task automatic run_random(input int cycles);
    int act;
    int age;
    bit last_d;
    bit ei, ed, ni, nd;
    bit xir, xdr, xerr, lat_we;
    logic [31:0] lat_addr, lat_wdata, xi, xd;
    bit ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    act = -1; age = 0; last_d = 1'b0;
    xir = 1'b0; xdr = 1'b0; xerr = 1'b0; lat_we = 1'b0;
    lat_addr = '0; lat_wdata = '0; xi = '0; xd = '0;
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; iaddr = '0; daddr = '0; dwdata = '0;
    for (int c = 0; c < cycles; c++) begin
      bus.i_req   = ireq;
      bus.i_addr  = iaddr;
      bus.d_req   = dreq;
      bus.d_we    = dwe;
      bus.d_addr  = daddr;
      bus.d_wdata = dwdata;
      bus.m_ack   = ($urandom_range(0, 2) == 0);
      bus.m_rdata = $urandom;
      chk("rnd_m_req", 32'(bus.m_req), 32'(act >= 0));
      chk("rnd_busy", 32'(busy), 32'(act >= 0));
      chk("rnd_i_ready", 32'(bus.i_ready), 32'(xir));
      chk("rnd_d_ready", 32'(bus.d_ready), 32'(xdr));
      chk("rnd_i_rdata", bus.i_rdata, xi);
      chk("rnd_d_rdata", bus.d_rdata, xd);
      chk("rnd_err", 32'(err_timeout), 32'(xerr));
      chk("rnd_m_addr", bus.m_addr, lat_addr);
      chk("rnd_m_we", 32'(bus.m_we), 32'(lat_we));
      if (lat_we) chk("rnd_m_wdata", bus.m_wdata, lat_wdata);
      ni = 1'b0;
      nd = 1'b0;
      if (act >= 0) begin
        if (bus.m_ack || age == int'(TO) - 1) begin
          if (act == 1) begin
            nd = 1'b1;
            xd = bus.m_ack ? bus.m_rdata : 32'd0;
          end else begin
            ni = 1'b1;
            xi = bus.m_ack ? bus.m_rdata : 32'd0;
          end
          if (!bus.m_ack) xerr = 1'b1;
          act = -1;
        end else begin
          age++;
        end
      end else begin
        ei = ireq && !xir;
        ed = dreq && !xdr;
        if (ed && (!ei || !last_d)) begin
          act = 1; age = 0; last_d = 1'b1;
          lat_we = dwe; lat_addr = daddr; lat_wdata = dwdata;
        end else if (ei) begin
          act = 0; age = 0; last_d = 1'b0;
          lat_we = 1'b0; lat_addr = iaddr;
        end
      end
      xir = ni;
      xdr = nd;
      tick();
      if (xir) begin
        ireq = $urandom_range(0, 1) != 0;
        iaddr = $urandom;
      end else if (!ireq && $urandom_range(0, 2) == 0) begin
        ireq = 1'b1;
        iaddr = $urandom;
      end
      if (xdr || (!dreq && $urandom_range(0, 2) == 0)) begin
        dreq   = xdr ? ($urandom_range(0, 1) != 0) : 1'b1;
        dwe    = $urandom_range(0, 1) != 0;
        daddr  = $urandom;
        dwdata = $urandom;
      end
    end
    clear_inputs();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h40,   32'h0, 32'h2002_0005, 0,  1'b0, 2,  32'h2002_0005, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h50,   32'h7, 32'hDEAD_BEEF, 2,  1'b0, 4,  32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h1234, 32'h0, 32'hCAFE_F00D, 1,  1'b0, 3,  32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h80,   32'h0, 32'h1357_9BDF, 5,  1'b1, 7,  32'h1357_9BDF, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h44,   32'h0, 32'h0BAD_F00D, 14, 1'b0, 16, 32'h0BAD_F00D, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h4C,   32'h0, 32'h1111_2222, 15, 1'b0, 17, 32'h1111_2222, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h60,   32'h0, 32'hFFFF_FFFF, 99, 1'b0, 17, 32'h0,         1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h48,   32'h0, 32'h55AA_55AA, 0,  1'b0, 2,  32'h55AA_55AA, 1'b1};

    do_reset();
    chk("rst_m_req", 32'(bus.m_req), 32'd0);
    chk("rst_m_we", 32'(bus.m_we), 32'd0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_m_wdata", bus.m_wdata, 32'd0);
    chk("rst_ready", 32'({bus.i_ready, bus.d_ready}), 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);

    // An ack while idle must not complete anything.
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h1234;
    tick();
    bus.m_ack = 1'b0;
    chk("idle_ack_ready", 32'({bus.i_ready, bus.d_ready}), 32'd0);
    chk("idle_ack_i_rdata", bus.i_rdata, 32'd0);
    chk("idle_ack_busy", 32'(busy), 32'd0);

    run_alternation();
    foreach (vecs[n]) run_vec(vecs[n]);
    run_reset_mid_serv();

    do_reset();
    run_random(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: maximum m_req cycles without m_ack before abort.
REQ-002 The block SHALL have parameter AW, default 32: address width.
REQ-003 The block SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: synchronous reset, active-low.
REQ-005 The block SHALL have port i_req, input, 1: fetch request, held until i_ready.
REQ-006 The block SHALL have port i_addr, input, AW: fetch address.
REQ-007 The block SHALL have port i_rdata, output, 32: fetched instruction.
REQ-008 The block SHALL have port i_ready, output, 1: one-cycle completion pulse for the fetch side.
REQ-009 The block SHALL have port d_req, input, 1: M-stage load/store request, held until d_ready.
REQ-010 The block SHALL have port d_we, input, 1: 1 = store.
REQ-011 The block SHALL have ports d_addr, input, AW and d_wdata, input, 32: data address and store data.
REQ-012 The block SHALL have port d_rdata, output, 32: load data.
REQ-013 The block SHALL have port d_ready, output, 1: one-cycle completion pulse for the data side.
REQ-014 The block SHALL have ports m_req, output, 1; m_we, output, 1; m_addr, output, AW; m_wdata, output, 32: unified memory request.
REQ-015 The block SHALL have ports m_rdata, input, 32 and m_ack, input, 1: memory response, valid when m_ack=1.
REQ-016 The block SHALL have ports busy, output, 1 (state != IDLE) and err_timeout, output, 1 (sticky abort flag).

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SERV_I and SERV_D.
REQ-018 In IDLE, if exactly one eligible request is present, the block SHALL grant it: latch addr, we and wdata (we=0 for the I side) and enter SERV_x on the next edge.
REQ-019 If both sides are eligible, the block SHALL grant the side not served last (round-robin); the last-served flag SHALL reset to I, so D wins the first tie.
REQ-020 A side SHALL be ineligible for grant in the cycle its x_ready is 1, because its req still reflects the completed access.
REQ-021 In SERV_x, m_req SHALL be 1 and m_we/m_addr/m_wdata SHALL equal the latched values, stable until termination.
REQ-022 The block SHALL drive m_req=0 in IDLE; m_addr, m_we and m_wdata SHALL then hold their last values.
REQ-023 When m_ack=1 in SERV_x, the block SHALL capture m_rdata into x_rdata, return to IDLE and assert x_ready for exactly the following cycle.
REQ-024 Minimum latency SHALL be: req at cycle 0, m_req at cycle 1, ack at cycle 1, x_ready at cycle 2.
REQ-025 x_rdata SHALL hold its value until the next completion on the same side.
REQ-026 For stores, d_rdata SHALL be updated with m_rdata on ack; its content is don't-care.
REQ-027 m_ack in IDLE SHALL be ignored.
REQ-028 A cycle counter SHALL clear on entry to SERV_x and increment each SERV cycle without ack.
REQ-029 If the counter reaches TIMEOUT-1 without ack, the block SHALL abort: x_rdata=32'h0, x_ready pulse, return to IDLE, err_timeout=1.
REQ-030 An m_ack in the abort cycle SHALL take priority over the abort.
REQ-031 err_timeout SHALL remain 1 until reset.
REQ-032 Requests dropped before x_ready SHALL have no effect on an access already granted, which SHALL complete normally.

Reset
REQ-033 While rst=0 at a clock edge: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, i_ready=d_ready=0, i_rdata=d_rdata=0, counter=0, last-served=I, err_timeout=0, busy=0.
REQ-034 A reset during SERV_x SHALL abandon the access without an x_ready pulse.
REQ-035 An m_ack arriving after reset release SHALL be ignored, because the block is in IDLE.

Structure
REQ-036 The shared package SHALL hold the state enum (IDLE, SERV_I, SERV_D), the default TIMEOUT and AW.
REQ-037 The timeout counter SHALL be a single sub-module, mem_arb_timer, with inputs clear and enable, parameter TIMEOUT and output expired.
REQ-038 The capture registers SHALL use the codebase's existing enable/reset flop cells.

Verification
REQ-039 Single fetch: i_req=1, i_addr=0x40, m_ack one cycle after m_req with m_rdata=0x20020005 -> m_addr=0x40, m_we=0; i_ready pulses once with i_rdata=0x20020005, 2 cycles after i_req.
REQ-040 Simultaneous i_req and d_req after reset -> D served first; I granted in the cycle after d_ready; no gap beyond the ineligible cycle.
REQ-041 Store: d_req=1, d_we=1, d_addr=0x50, d_wdata=0x7, ack after 3 cycles -> m_we=1, m_wdata=0x7 stable over all 3 cycles; d_ready 1 cycle after ack.
REQ-042 Both sides requesting continuously for 8 accesses -> grants strictly alternate D, I, D, I...; no side waits for more than one access.
REQ-043 No m_ack with TIMEOUT=16 -> abort after 16 SERV cycles: x_ready=1, x_rdata=0, err_timeout=1 and stays 1; the next request is served normally.
REQ-044 rst=0 asserted mid SERV_D, then m_ack after release -> no d_ready, m_req=0 next cycle, state IDLE, ack ignored.
